// File: rtl/abl_core_pkg.sv
// Shared encodings for the ABL multi-cycle core: opcodes, FSM states and
// the bit positions of the 16-bit instruction word.
package abl_core_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 2;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned STATE_W = 3;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RA_MSB  = 11;
  localparam int unsigned RA_LSB  = 10;
  localparam int unsigned RB_MSB  = 9;
  localparam int unsigned RB_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_AND = 4'h4;
  localparam logic [OP_W-1:0] OP_OR  = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR = 4'h6;
  localparam logic [OP_W-1:0] OP_SHL = 4'h7;
  localparam logic [OP_W-1:0] OP_LD  = 4'h8;
  localparam logic [OP_W-1:0] OP_ST  = 4'h9;
  localparam logic [OP_W-1:0] OP_IN  = 4'hA;
  localparam logic [OP_W-1:0] OP_OUT = 4'hB;
  localparam logic [OP_W-1:0] OP_JMP = 4'hC;
  localparam logic [OP_W-1:0] OP_BZ  = 4'hD;
  localparam logic [OP_W-1:0] OP_BN  = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam logic [STATE_W-1:0] S_WAIT  = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] S_EXEC  = 3'd2;
  localparam logic [STATE_W-1:0] S_MEM   = 3'd3;
  localparam logic [STATE_W-1:0] S_HALT  = 3'd4;

endpackage

// File: rtl/abl_alu_w.sv
// Combinational DATA_W-wide ALU for opcodes 2-7; result plus zero/negative flags.
module abl_alu_w
  import abl_core_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result_c,
  output logic              o_z_c,
  output logic              o_n_c
);

  logic [DATA_W-1:0] w_result;

  always_comb begin
    w_result = '0;
    case (i_op)
      OP_ADD:  w_result = i_a + i_b;
      OP_SUB:  w_result = i_a - i_b;
      OP_AND:  w_result = i_a & i_b;
      OP_OR:   w_result = i_a | i_b;
      OP_XOR:  w_result = i_a ^ i_b;
      OP_SHL:  w_result = {i_a[DATA_W-2:0], 1'b0};
      default: w_result = '0;
    endcase
  end

  assign o_result_c = w_result;
  assign o_z_c      = (w_result == '0);
  assign o_n_c      = w_result[DATA_W-1];

endmodule

// File: rtl/abl_multicycle_core.sv
// ABL multi-cycle core: tick-throttled WAIT/FETCH/EXEC/MEM/HALT sequencer with
// req/ack instruction and data ports, four GPRs and Z/N flags.
module abl_multicycle_core
  import abl_core_pkg::*;
#(
  parameter int unsigned     DATA_W  = 8,
  parameter int unsigned     CLK_DIV = 1,
  parameter logic [PC_W-1:0] RST_PC  = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_term,
  output logic [DATA_W-1:0]  out_term,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [PC_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               halted
);

  localparam int unsigned        TICK_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(CLK_DIV - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic               w_tick;

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [DATA_W-1:0]  r_gpr [4];
  logic [DATA_W-1:0]  r_out_term;
  logic               r_z;
  logic               r_n;
  logic               r_imem_req;
  logic               r_dmem_req;
  logic               r_dmem_we;
  logic [PC_W-1:0]    r_dmem_addr;
  logic [DATA_W-1:0]  r_dmem_wdata;
  logic               r_halted;

  logic [OP_W-1:0]    w_op;
  logic [REG_W-1:0]   w_ra;
  logic [REG_W-1:0]   w_rb;
  logic [IMM_W-1:0]   w_imm;
  logic [DATA_W-1:0]  w_ra_val;
  logic [DATA_W-1:0]  w_rb_val;
  logic [DATA_W-1:0]  w_alu_res;
  logic               w_alu_z;
  logic               w_alu_n;
  logic               w_imem_fire;
  logic               w_dmem_fire;
  logic [PC_W-1:0]    w_pc_inc;

  assign w_op     = r_ir[OP_MSB:OP_LSB];
  assign w_ra     = r_ir[RA_MSB:RA_LSB];
  assign w_rb     = r_ir[RB_MSB:RB_LSB];
  assign w_imm    = r_ir[IMM_MSB:IMM_LSB];
  assign w_ra_val = r_gpr[w_ra];
  assign w_rb_val = r_gpr[w_rb];
  assign w_pc_inc = r_pc + PC_W'(1);

  // Acks are only honoured while the matching request is up.
  assign w_imem_fire = r_imem_req & imem_ack;
  assign w_dmem_fire = r_dmem_req & dmem_ack;
  assign w_tick      = (r_tick_cnt == TICK_LAST);

  abl_alu_w #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op       (w_op),
    .i_a        (w_ra_val),
    .i_b        (w_rb_val),
    .o_result_c (w_alu_res),
    .o_z_c      (w_alu_z),
    .o_n_c      (w_alu_n)
  );

  // Free-running step-enable counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WAIT:  if (w_tick) w_next_state = S_FETCH;
      S_FETCH: if (w_imem_fire) w_next_state = S_EXEC;
      S_EXEC: begin
        if ((w_op == OP_LD) || (w_op == OP_ST)) begin
          w_next_state = S_MEM;
        end else if (w_op == OP_HLT) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_MEM:   if (w_dmem_fire) w_next_state = S_WAIT;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_WAIT;
    endcase
  end

  // Datapath and registered handshake outputs; requests track the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RST_PC;
      r_ir         <= '0;
      for (int i = 0; i < 4; i++) r_gpr[i] <= '0;
      r_out_term   <= '0;
      r_z          <= 1'b0;
      r_n          <= 1'b0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_halted     <= 1'b0;
    end else begin
      r_imem_req <= (w_next_state == S_FETCH);
      r_dmem_req <= (w_next_state == S_MEM);
      r_halted   <= (w_next_state == S_HALT);

      if ((r_state == S_FETCH) && w_imem_fire) begin
        r_ir <= imem_rdata;
      end

      if (r_state == S_EXEC) begin
        case (w_op)
          OP_NOP: r_pc <= w_pc_inc;
          OP_LDI: begin
            r_gpr[w_ra] <= DATA_W'(w_imm);
            r_pc        <= w_pc_inc;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
            r_gpr[w_ra] <= w_alu_res;
            r_z         <= w_alu_z;
            r_n         <= w_alu_n;
            r_pc        <= w_pc_inc;
          end
          OP_LD, OP_ST: begin
            r_dmem_addr  <= w_imm;
            r_dmem_we    <= (w_op == OP_ST);
            r_dmem_wdata <= w_ra_val;
          end
          OP_IN: begin
            r_gpr[w_ra] <= in_term;
            r_pc        <= w_pc_inc;
          end
          OP_OUT: begin
            r_out_term <= w_ra_val;
            r_pc       <= w_pc_inc;
          end
          OP_JMP: r_pc <= w_imm;
          OP_BZ:  r_pc <= r_z ? w_imm : w_pc_inc;
          OP_BN:  r_pc <= r_n ? w_imm : w_pc_inc;
          OP_HLT: r_pc <= r_pc;
        endcase
      end

      if ((r_state == S_MEM) && w_dmem_fire) begin
        if (!r_dmem_we) r_gpr[w_ra] <= dmem_rdata;
        r_pc <= w_pc_inc;
      end
    end
  end

  assign out_term   = r_out_term;
  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign halted     = r_halted;

endmodule

// File: tb/tb_abl_multicycle_core.sv
// Directed bench: a 16-bit core with RST_PC=0x40 runs hand-written programs,
// and an 8-bit CLK_DIV=4 core runs a NOP stream to show fetch throttling.
module tb_abl_multicycle_core;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] in_term = '0;
  logic [DW-1:0] out_term;
  logic          imem_req;
  logic [7:0]    imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic [7:0]    dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          halted;

  logic [7:0]    d4_out_term;
  logic          d4_imem_req;
  logic [7:0]    d4_imem_addr;
  logic          d4_imem_ack;
  logic          d4_dmem_req;
  logic          d4_dmem_we;
  logic [7:0]    d4_dmem_addr;
  logic [7:0]    d4_dmem_wdata;
  logic          d4_halted;

  logic          imem_hold = 1'b1;
  logic          ack_noise = 1'b0;
  int            dmem_delay = 3;
  logic [15:0]   imem [256];
  logic [DW-1:0] dmem [256];
  int            dcnt;
  int            dreq_cyc;
  logic          daddr_bad;
  int            cyc = 0;
  logic [7:0]    f_addr [$];
  int            f_cyc [$];
  int            d4_rise [$];
  logic          d4_prev = 1'b0;
  int            errors = 0;
  int            checks = 0;

  abl_multicycle_core #(.DATA_W(DW), .CLK_DIV(1), .RST_PC(8'h40)) u_dut (
    .clk(clk), .rst(rst), .in_term(in_term), .out_term(out_term),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted)
  );

  abl_multicycle_core #(.DATA_W(8), .CLK_DIV(4), .RST_PC(8'h00)) u_dut4 (
    .clk(clk), .rst(rst), .in_term(8'h00), .out_term(d4_out_term),
    .imem_req(d4_imem_req), .imem_addr(d4_imem_addr), .imem_ack(d4_imem_ack), .imem_rdata(16'h0000),
    .dmem_req(d4_dmem_req), .dmem_we(d4_dmem_we), .dmem_addr(d4_dmem_addr), .dmem_wdata(d4_dmem_wdata),
    .dmem_ack(1'b0), .dmem_rdata(8'h00), .halted(d4_halted)
  );

  assign imem_ack    = (imem_req && !imem_hold) || ack_noise;
  assign imem_rdata  = imem[imem_addr];
  assign dmem_ack    = (dmem_req && (dcnt >= dmem_delay)) || ack_noise;
  assign dmem_rdata  = dmem[dmem_addr];
  assign d4_imem_ack = d4_imem_req;

  // Cycle counter and log of every completed fetch.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_req && imem_ack) begin
      f_addr.push_back(imem_addr);
      f_cyc.push_back(cyc);
    end
  end

  // Data memory with dmem_delay wait-states, plus request-window monitor.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt      <= 0;
      dreq_cyc  <= 0;
      daddr_bad <= 1'b0;
    end else begin
      if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
      else dcnt <= 0;
      if (dmem_req) begin
        dreq_cyc <= dreq_cyc + 1;
        if (dmem_addr != 8'h10) daddr_bad <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  always @(negedge clk) begin
    if (d4_imem_req && !d4_prev) d4_rise.push_back(cyc);
    d4_prev <= d4_imem_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(input int n, input string tag);
    int k;
    k = 0;
    while ((f_addr.size() < n) && (k < 400)) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(f_addr.size() >= n), 32'd1);
  endtask

  initial begin
    int fb, c0, rb, nf, req_hi;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[8'h40] = 16'h1005;  // LDI R0,5
    imem[8'h41] = 16'h1405;  // LDI R1,5
    imem[8'h42] = 16'h3100;  // SUB R0,R1
    imem[8'h43] = 16'hD020;  // BZ 0x20
    imem[8'h20] = 16'h18A5;  // LDI R2,0xA5
    imem[8'h21] = 16'h9810;  // ST R2,0x10
    imem[8'h22] = 16'h8C10;  // LD R3,0x10
    imem[8'h23] = 16'hBC00;  // OUT R3
    imem[8'h24] = 16'hC050;  // JMP 0x50
    imem[8'h50] = 16'h10FF;  // LDI R0,0xFF
    imem[8'h51] = 16'h2000;  // ADD R0,R0
    imem[8'h52] = 16'hE070;  // BN 0x70 (not taken)
    imem[8'h53] = 16'hB000;  // OUT R0
    for (int i = 8'h54; i <= 8'h5A; i++) imem[i] = 16'h7000;  // SHL R0 x7
    imem[8'h5B] = 16'hE060;  // BN 0x60 (taken)
    imem[8'h60] = 16'hB000;  // OUT R0
    imem[8'h61] = 16'hC0FF;  // JMP 0xFF
    imem[8'hFF] = 16'h0000;  // NOP
    imem[8'h00] = 16'hF000;  // HLT

    repeat (3) @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_out_term", 32'(out_term), 32'd0);
    check("rst_pc", 32'(imem_addr), 32'h40);
    check("rst_d4_req", 32'(d4_imem_req), 32'd0);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("fetch_req_held", 32'(imem_req), 32'd1);
    check("fetch_addr_held", 32'(imem_addr), 32'h40);
    #2 rst = 1'b0;
    #1;
    check("async_req_drop", 32'(imem_req), 32'd0);
    check("async_pc", 32'(imem_addr), 32'h40);

    @(negedge clk);
    rst = 1'b1;
    imem_hold = 1'b0;
    c0 = cyc;
    fb = f_addr.size();
    rb = d4_rise.size();

    wait_fetch(fb + 5, "wait_bz");
    check("first_fetch_addr", 32'(f_addr[fb]), 32'h40);
    for (int k = 0; k < 4; k++) check("alu_latency", 32'(f_cyc[fb+k+1] - f_cyc[fb+k]), 32'd3);
    check("bz_taken_addr", 32'(f_addr[fb+4]), 32'h20);

    wait_fetch(fb + 9, "wait_jmp50");
    check("st_latency_ws", 32'(f_cyc[fb+6] - f_cyc[fb+5]), 32'd7);
    check("ld_latency_ws", 32'(f_cyc[fb+7] - f_cyc[fb+6]), 32'd7);
    check("dmem_req_cycles", 32'(dreq_cyc), 32'd8);
    check("dmem_addr_stable", 32'(daddr_bad), 32'd0);
    check("store_data", 32'(dmem[8'h10]), 32'h00A5);
    check("out_ld_value", 32'(out_term), 32'h00A5);

    wait_fetch(fb + 14, "wait_add");
    check("bn_not_taken", 32'(f_addr[fb+12]), 32'h53);
    check("add_wide", 32'(out_term), 32'h01FE);

    wait_fetch(fb + 23, "wait_shl");
    check("bn_taken", 32'(f_addr[fb+21]), 32'h60);
    check("shl_wide", 32'(out_term), 32'hFF00);

    wait_fetch(fb + 25, "wait_wrap");
    check("pc_wrap", 32'(f_addr[fb+24]), 32'h00);

    repeat (2) @(negedge clk);
    check("halted_set", 32'(halted), 32'd1);
    nf = f_addr.size();
    req_hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ack_noise = ~ack_noise;
      if (imem_req || dmem_req) req_hi++;
    end
    ack_noise = 1'b0;
    check("halt_no_req", 32'(req_hi), 32'd0);
    check("halt_no_fetch", 32'(f_addr.size() - nf), 32'd0);
    check("halt_pc_frozen", 32'(imem_addr), 32'h01 - 32'h01);
    check("halted_hold", 32'(halted), 32'd1);

    check("d4_rise_count", 32'(d4_rise.size() >= rb + 4), 32'd1);
    check("d4_first_rise", 32'(d4_rise[rb] - c0), 32'd4);
    for (int k = 0; k < 3; k++) check("d4_rise_period", 32'(d4_rise[rb+k+1] - d4_rise[rb+k]), 32'd4);

    rst = 1'b0;
    #1;
    check("halt_cleared", 32'(halted), 32'd0);
    check("halt_rst_pc", 32'(imem_addr), 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
